// File: rtl/lcd_frame_signature_pkg.sv
// Shared timing defaults, CRC constants, FSM state encoding and the
// frame-signature payload for the LCD frame signature monitor.
package lcd_frame_signature_pkg;

    localparam int unsigned MTL_H_TOTAL     = 1056;
    localparam int unsigned MTL_V_TOTAL     = 525;
    localparam int unsigned MTL_H_ACT_START = 50;
    localparam int unsigned MTL_H_ACT_LEN   = 800;
    localparam int unsigned MTL_V_ACT_START = 23;
    localparam int unsigned MTL_V_ACT_LEN   = 480;
    localparam int unsigned MTL_PIX_W       = 24;

    localparam int unsigned X_W         = 11;
    localparam int unsigned Y_W         = 10;
    localparam int unsigned CRC_W       = 32;
    localparam int unsigned PIX_CNT_W   = 20;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam logic [CRC_W-1:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [CRC_W-1:0] CRC32_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_LOCKED  = 2'd2
    } fsm_state_e;

    typedef struct packed {
        logic [CRC_W-1:0]     crc;
        logic [PIX_CNT_W-1:0] pix_count;
    } frame_sig_t;

endpackage

// File: rtl/lcd_frame_signature_crc32_step.sv
// One-clock CRC-32 update over a full pixel word, MSB first,
// non-reflected, no final XOR.
module crc32_step
    import lcd_frame_signature_pkg::*;
#(
    parameter int unsigned PIX_W = MTL_PIX_W
) (
    input  logic [CRC_W-1:0] crc,
    input  logic [PIX_W-1:0] data,
    output logic [CRC_W-1:0] crc_next_c
);

    logic [PIX_W-1:0] shift;
    logic             fb;

    // Bit-serial recurrence unrolled across the pixel word.
    always_comb begin
        crc_next_c = crc;
        shift      = data;
        fb         = 1'b0;
        for (int i = 0; i < int'(PIX_W); i++) begin
            fb         = crc_next_c[CRC_W-1] ^ shift[PIX_W-1];
            crc_next_c = {crc_next_c[CRC_W-2:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
            shift      = shift << 1;
        end
    end

endmodule

// File: rtl/lcd_frame_signature.sv
// Taps the panel HSD/VSD/RGB bus, locks to frame timing, streams active
// pixel coordinates and produces a per-frame CRC-32 signature.
module lcd_frame_signature
    import lcd_frame_signature_pkg::*;
#(
    parameter int unsigned H_TOTAL     = MTL_H_TOTAL,
    parameter int unsigned V_TOTAL     = MTL_V_TOTAL,
    parameter int unsigned H_ACT_START = MTL_H_ACT_START,
    parameter int unsigned H_ACT_LEN   = MTL_H_ACT_LEN,
    parameter int unsigned V_ACT_START = MTL_V_ACT_START,
    parameter int unsigned V_ACT_LEN   = MTL_V_ACT_LEN,
    parameter int unsigned PIX_W       = MTL_PIX_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_hsd,
    input  logic                   i_vsd,
    input  logic [PIX_W-1:0]       i_rgb,
    input  logic                   i_err_clr,
    output logic                   o_locked,
    output logic                   o_pix_valid,
    output logic [X_W-1:0]         o_x,
    output logic [Y_W-1:0]         o_y,
    output logic [PIX_W-1:0]       o_rgb,
    output logic                   o_frame_done,
    output logic [CRC_W-1:0]       o_frame_crc,
    output logic [PIX_CNT_W-1:0]   o_pix_count,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt,
    output logic                   o_err_h,
    output logic                   o_err_v
);

    logic                 r_hsd;
    logic                 r_vsd;
    logic [X_W-1:0]       r_x;
    logic [Y_W-1:0]       r_y;
    fsm_state_e           state;
    logic [CRC_W-1:0]     crc_acc;
    logic [CRC_W-1:0]     crc_next;
    logic [PIX_CNT_W-1:0] pix_acc;
    frame_sig_t           sig;

    logic hs_fall;
    logic vs_fall;
    logic in_x;
    logic in_y;
    logic active;
    logic err_h;
    logic err_v;

    assign hs_fall = r_hsd & ~i_hsd;
    assign vs_fall = r_vsd & ~i_vsd;

    assign in_x = (r_x >= X_W'(H_ACT_START)) && (r_x < X_W'(H_ACT_START + H_ACT_LEN));
    assign in_y = (r_y >= Y_W'(V_ACT_START)) && (r_y < Y_W'(V_ACT_START + V_ACT_LEN));

    assign active = (state == ST_LOCKED) && i_en && in_x && in_y;
    assign err_h  = (state == ST_LOCKED) && hs_fall && (r_x != X_W'(H_TOTAL - 1));
    assign err_v  = (state == ST_LOCKED) && vs_fall && (r_y != Y_W'(V_TOTAL - 1));

    assign o_frame_crc = sig.crc;
    assign o_pix_count = sig.pix_count;

    crc32_step #(
        .PIX_W (PIX_W)
    ) u_crc32_step (
        .crc        (crc_acc),
        .data       (i_rgb),
        .crc_next_c (crc_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hsd        <= 1'b1;
            r_vsd        <= 1'b1;
            r_x          <= '0;
            r_y          <= '0;
            state        <= ST_IDLE;
            crc_acc      <= CRC32_INIT;
            pix_acc      <= '0;
            sig          <= '0;
            o_locked     <= 1'b0;
            o_pix_valid  <= 1'b0;
            o_x          <= '0;
            o_y          <= '0;
            o_rgb        <= '0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
            o_err_h      <= 1'b0;
            o_err_v      <= 1'b0;
        end else begin
            r_hsd        <= i_hsd;
            r_vsd        <= i_vsd;
            o_pix_valid  <= active;
            o_frame_done <= 1'b0;

            // Saturating raster counters; VSD restarts the line count.
            if (hs_fall) begin
                r_x <= '0;
            end else if (r_x != '1) begin
                r_x <= r_x + X_W'(1);
            end
            if (vs_fall) begin
                r_y <= '0;
            end else if (hs_fall && (r_y != '1)) begin
                r_y <= r_y + Y_W'(1);
            end

            if (active) begin
                o_x     <= r_x - X_W'(H_ACT_START);
                o_y     <= r_y - Y_W'(V_ACT_START);
                o_rgb   <= i_rgb;
                crc_acc <= crc_next;
                pix_acc <= pix_acc + PIX_CNT_W'(1);
            end

            // A new error in the same cycle beats the clear request.
            if (err_h) begin
                o_err_h <= 1'b1;
            end else if (i_err_clr) begin
                o_err_h <= 1'b0;
            end
            if (err_v) begin
                o_err_v <= 1'b1;
            end else if (i_err_clr) begin
                o_err_v <= 1'b0;
            end

            if (!i_en) begin
                state    <= ST_IDLE;
                o_locked <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_WAIT_VS;
                        o_locked <= 1'b0;
                    end
                    ST_WAIT_VS: begin
                        if (vs_fall) begin
                            state    <= ST_LOCKED;
                            o_locked <= 1'b1;
                            crc_acc  <= CRC32_INIT;
                            pix_acc  <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Timing error drops lock; the partial frame is discarded.
                        if (err_h || err_v) begin
                            state    <= ST_WAIT_VS;
                            o_locked <= 1'b0;
                        end else if (vs_fall) begin
                            o_frame_done  <= 1'b1;
                            sig.crc       <= crc_acc;
                            sig.pix_count <= pix_acc;
                            o_frame_cnt   <= o_frame_cnt + FRAME_CNT_W'(1);
                            crc_acc       <= CRC32_INIT;
                            pix_acc       <= '0;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
